pic_cmd_interface: RTL and testbench
====================================

# pic_cmd_interface

Synchronous CPU-bus front end for the interrupt controller. Decodes chip-selected read/write strobes into ICW1–ICW4 initialisation sequencing and OCW1–OCW3 operational commands, holds the resulting control registers, and returns IRR/ISR/IMR/poll status on reads. Sits between the external 8-bit data bus and the priority resolver / in-service logic. Generalises interrupt-line count via `NUM_IR`.

## Interface
- `NUM_IR`, 8, number of interrupt request lines (1..8); width of IMR/IRR/ISR.
- `LVL_W`, 3, width of level fields (fixed 3; ≥ clog2(`NUM_IR`)).
- Clock and reset: one clock; reset is synchronous and active-low.
- `CLK` in 1, clock; all state changes on rising edge.
- `RST_N` in 1, synchronous active-low reset.
- `CS_N`, `WR_N`, `RD_N` in 1 each, bus strobes, synchronous to `CLK`.
- `A0` in 1, register select.
- `DIN` in 8, write data.
- `IRR`, `ISR` in `NUM_IR`, status from request/in-service registers.
- `POLL_VALID` in 1, `POLL_LEVEL` in `LVL_W`, highest pending unmasked request from resolver.
- `DOUT` out 8, read data; `DOE` out 1, drive-enable for `DOUT`.
- `INIT_DONE` out 1, initialisation sequence complete.
- `LTIM`, `SNGL` out 1 each, from ICW1 D3/D1.
- `VEC_BASE` out 5, ICW2 D7:D3.
- `CAS_CFG` out 8, ICW3.
- `ICW4_CFG` out 5, ICW4 D4:D0 (SFNM, BUF, M/S, AEOI, µPM).
- `IMR` out `NUM_IR`, OCW1 mask.
- `OCW2_STB` out 1, one-cycle pulse on OCW2 write; `OCW2_CMD` out 3 (R, SL, EOI), `OCW2_LVL` out `LVL_W`.
- `SMM` out 1, special mask mode.
- `POLL_ACK` out 1, one-cycle pulse when a poll read is served.

## Operation
- Write event: first cycle with `CS_N`=0, `WR_N`=0 after a cycle with either high (falling-edge detect on registered `WR_N|CS_N`); exactly one event per low pulse. Read event defined identically on `RD_N`.
- Simultaneous `WR_N` and `RD_N` low: write processed, read ignored, `DOE`=0.
- FSM states: `IDLE_UNINIT`, `WAIT_ICW2`, `WAIT_ICW3`, `WAIT_ICW4`, `READY`.
- Any state, write with A0=0, D4=1 → ICW1: latch LTIM/SNGL/IC4, clear IMR, `SMM`=0, read select=IRR, poll disarmed, `INIT_DONE`=0, clear `CAS_CFG` and `ICW4_CFG`, go `WAIT_ICW2`.
- `WAIT_ICW2`: A0=1 write → `VEC_BASE`; next `WAIT_ICW3` if SNGL=0, else `WAIT_ICW4` if IC4=1, else `READY`.
- `WAIT_ICW3`: A0=1 write → `CAS_CFG`; next `WAIT_ICW4` if IC4 else `READY`.
- `WAIT_ICW4`: A0=1 write → `ICW4_CFG`; next `READY`.
- In init states, A0=0/D4=0 writes ignored. `INIT_DONE`=1 on entering `READY`.
- `READY`: A0=1 → OCW1, `IMR` ← `DIN[NUM_IR-1:0]`. A0=0, D4=0, D3=0 → OCW2: `OCW2_CMD`←D7:D5, `OCW2_LVL`←D2:D0, `OCW2_STB`=1 one cycle. A0=0, D4=0, D3=1 → OCW3: if D1 (RR) then read select←D0 (0=IRR,1=ISR); if D6 (ESMM) then `SMM`←D5; D2 (P) per Configuration. OCW writes in `IDLE_UNINIT` ignored.
- Read: A0=1 → IMR; A0=0 → IRR or ISR per read select. Unused upper bits (≥`NUM_IR`) read 0. Reads permitted in every state.

## Timing
- Reset values: state `IDLE_UNINIT`; all outputs 0; read select IRR.
- Write latency: register outputs update on the clock edge that samples the write event (visible next cycle). `OCW2_STB` high for that one cycle only.
- Read: `DOUT` registered at the read-event edge, held until `RD_N` or `CS_N` rises; `DOE`=1 from the cycle after the event while `RD_N`=`CS_N`=0; `DOE`=0 otherwise; `DOUT` = 0 when `DOE`=0.
- Status snapshot taken at the event edge; `IRR`/`ISR` changes during the pulse not reflected.
- Reset mid-sequence: returns to `IDLE_UNINIT`, pending strobes re-armed only after strobe goes high.

## Configuration
- `PIC_POLL_CMD_EN` defined: OCW3 with D2=1 arms poll. Next A0=0 read returns {`POLL_VALID`, 4'b0, `POLL_LEVEL`}, pulses `POLL_ACK` one cycle at the event edge if `POLL_VALID`=1, disarms poll. ICW1 or reset disarms.
- Not defined: OCW3 D2 ignored, `POLL_ACK` tied 0, reads unaffected.

## Test plan
- Reset, then ICW1=0x13 (A0=0), ICW2=0x20 (A0=1), ICW4=0x03 (A0=1) → `SNGL`=1, ICW3 skipped, `VEC_BASE`=0x04, `ICW4_CFG`=0x03, `INIT_DONE`=1 after third write.
- ICW1=0x11, ICW2=0x08, ICW3=0x04, ICW4=0x01 → `CAS_CFG`=0x04, `ICW4_CFG`=0x01; extra ICW1=0x10 in `WAIT_ICW3` restarts: `INIT_DONE`=0, `CAS_CFG`=0.
- `READY`, A0=1 write 0xA5 → `IMR`=0xA5; read A0=1 → `DOUT`=0xA5, `DOE` one cycle after event; `NUM_IR`=4 build → `IMR`=0x5, read 0x05.
- OCW2=0x61 → `OCW2_STB` exactly one cycle, `OCW2_CMD`=3'b011, `OCW2_LVL`=1; WR_N held low 5 cycles → still one pulse.
- OCW3=0x0B, `ISR`=0x10 → A0=0 read 0x10; OCW3=0x0A, `IRR`=0x81 → 0x81; OCW3=0x68 → `SMM`=1.
- With `PIC_POLL_CMD_EN`: OCW3=0x0C, `POLL_VALID`=1, `POLL_LEVEL`=5 → read 0x85, `POLL_ACK` one cycle; following read returns IRR.

Source files
------------

// File: rtl/pic_cmd_interface.sv
// pic_cmd_interface: CPU-bus command decoder and status read-back for the interrupt controller.
// Optional poll command support is enabled by defining PIC_POLL_CMD_EN.
module pic_cmd_interface #(
    parameter int NUM_IR = 8,
    parameter int LVL_W  = 3
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CS_N,
    input  logic              WR_N,
    input  logic              RD_N,
    input  logic              A0,
    input  logic [7:0]        DIN,
    input  logic [NUM_IR-1:0] IRR,
    input  logic [NUM_IR-1:0] ISR,
    input  logic              POLL_VALID,
    input  logic [LVL_W-1:0]  POLL_LEVEL,
    output logic [7:0]        DOUT,
    output logic              DOE,
    output logic              INIT_DONE,
    output logic              LTIM,
    output logic              SNGL,
    output logic [4:0]        VEC_BASE,
    output logic [7:0]        CAS_CFG,
    output logic [4:0]        ICW4_CFG,
    output logic [NUM_IR-1:0] IMR,
    output logic              OCW2_STB,
    output logic [2:0]        OCW2_CMD,
    output logic [LVL_W-1:0]  OCW2_LVL,
    output logic              SMM,
    output logic              POLL_ACK
);
    typedef enum logic [2:0] {IDLE_UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} state_t;
    state_t state, nxt;
    logic wr_act, rd_act, wr_prev, rd_prev, wr_ev, rd_ev;
    logic icw1, ocw1, ocw2, ocw3, poll_rd, poll_arm;
    logic ic4, rsel, rd_hold;
    logic [7:0] rd_data, dout_q;

    assign wr_act = ~CS_N & ~WR_N;
    assign rd_act = ~CS_N & ~RD_N;

    // strobe history; held "active" through reset so a strobe low across reset needs a high first
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_prev <= 1'b1;
            rd_prev <= 1'b1;
        end else begin
            wr_prev <= wr_act;
            rd_prev <= rd_act;
        end
    end

    // initialisation sequencer state register
    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE_UNINIT;
        else        state <= nxt;
    end

    // next state: ICW1 restarts from anywhere, A0=1 writes step through ICW2..ICW4
    always_comb begin
        nxt = state;
        if (icw1)
            nxt = WAIT_ICW2;
        else if (wr_ev && A0 && state == WAIT_ICW2)
            nxt = !SNGL ? WAIT_ICW3 : ic4 ? WAIT_ICW4 : READY;
        else if (wr_ev && A0 && state == WAIT_ICW3)
            nxt = ic4 ? WAIT_ICW4 : READY;
        else if (wr_ev && A0 && state == WAIT_ICW4)
            nxt = READY;
    end

    // command decode and state-derived outputs; a read colliding with a write is dropped
    always_comb begin
        wr_ev     = wr_act & ~wr_prev;
        rd_ev     = rd_act & ~rd_prev & WR_N;
        INIT_DONE = state == READY;
        icw1      = wr_ev & ~A0 & DIN[4];
        ocw1      = wr_ev & A0 & INIT_DONE;
        ocw2      = wr_ev & ~A0 & ~DIN[4] & ~DIN[3] & INIT_DONE;
        ocw3      = wr_ev & ~A0 & ~DIN[4] & DIN[3] & INIT_DONE;
        poll_rd   = rd_ev & ~A0 & poll_arm;
    end

    // read data source: poll word when armed, otherwise IMR or the selected status register
    always_comb begin
        rd_data = '0;
        rd_data[NUM_IR-1:0] = A0 ? IMR : rsel ? ISR : IRR;
        if (poll_rd) rd_data = {POLL_VALID, 4'b0, POLL_LEVEL};
    end

    // control registers written by ICW/OCW commands
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            LTIM     <= 1'b0;
            SNGL     <= 1'b0;
            ic4      <= 1'b0;
            VEC_BASE <= '0;
            CAS_CFG  <= '0;
            ICW4_CFG <= '0;
            IMR      <= '0;
            OCW2_STB <= 1'b0;
            OCW2_CMD <= '0;
            OCW2_LVL <= '0;
            SMM      <= 1'b0;
            rsel     <= 1'b0;
        end else begin
            OCW2_STB <= ocw2;
            if (icw1) begin
                LTIM     <= DIN[3];
                SNGL     <= DIN[1];
                ic4      <= DIN[0];
                IMR      <= '0;
                SMM      <= 1'b0;
                rsel     <= 1'b0;
                CAS_CFG  <= '0;
                ICW4_CFG <= '0;
            end
            if (wr_ev && A0 && state == WAIT_ICW2) VEC_BASE <= DIN[7:3];
            if (wr_ev && A0 && state == WAIT_ICW3) CAS_CFG <= DIN;
            if (wr_ev && A0 && state == WAIT_ICW4) ICW4_CFG <= DIN[4:0];
            if (ocw1) IMR <= DIN[NUM_IR-1:0];
            if (ocw2) begin
                OCW2_CMD <= DIN[7:5];
                OCW2_LVL <= DIN[LVL_W-1:0];
            end
            if (ocw3 && DIN[1]) rsel <= DIN[0];
            if (ocw3 && DIN[6]) SMM <= DIN[5];
        end
    end

    // read snapshot taken at the event edge and held for the rest of the pulse
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rd_hold <= 1'b0;
            dout_q  <= '0;
        end else begin
            if (rd_ev) dout_q <= rd_data;
            rd_hold <= rd_ev | (rd_hold & rd_act);
        end
    end

    assign DOE  = rd_hold & rd_act & WR_N;
    assign DOUT = DOE ? dout_q : 8'h00;

`ifdef PIC_POLL_CMD_EN
    // poll is one-shot: armed by OCW3 P, consumed by the next A0=0 read, cleared by ICW1
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            poll_arm <= 1'b0;
            POLL_ACK <= 1'b0;
        end else begin
            POLL_ACK <= poll_rd & POLL_VALID;
            if (icw1 || poll_rd) poll_arm <= 1'b0;
            else if (ocw3 && DIN[2]) poll_arm <= 1'b1;
        end
    end
`else
    assign poll_arm = 1'b0;
    assign POLL_ACK = 1'b0;
`endif
endmodule

// File: tb/tb_pic_cmd_interface.sv
// tb_pic_cmd_interface: randomized scoreboard bench for pic_cmd_interface against a command-level model.
module tb_pic_cmd_interface;
    logic       CLK = 0, RST_N = 0, CS_N = 1, WR_N = 1, RD_N = 1, A0 = 0;
    logic [7:0] DIN = 0, IRR = 0, ISR = 0;
    logic       POLL_VALID = 0;
    logic [2:0] POLL_LEVEL = 0;
    logic [7:0] DOUT, CAS_CFG, IMR;
    logic       DOE, INIT_DONE, LTIM, SNGL, OCW2_STB, SMM, POLL_ACK;
    logic [4:0] VEC_BASE, ICW4_CFG;
    logic [2:0] OCW2_CMD, OCW2_LVL;
    logic [7:0] dout4, cas4;
    logic       doe4, init4, ltim4, sngl4, stb4, smm4, ack4;
    logic [4:0] vec4, icw4_4;
    logic [3:0] imr4;
    logic [2:0] cmd4, lvl4;

    int errs = 0, checks = 0;
    logic [7:0] exp_q[$];
    logic doe_q = 0;

    int         ph;
    bit         m_sngl, m_ic4, m_ltim, m_smm, m_rsel, m_poll, m_stb;
    logic [4:0] m_vec, m_icw4;
    logic [7:0] m_cas, m_imr;
    logic [2:0] m_cmd, m_lvl;

    pic_cmd_interface #(.NUM_IR(8), .LVL_W(3)) dut (
        .CLK(CLK), .RST_N(RST_N), .CS_N(CS_N), .WR_N(WR_N), .RD_N(RD_N), .A0(A0), .DIN(DIN),
        .IRR(IRR), .ISR(ISR), .POLL_VALID(POLL_VALID), .POLL_LEVEL(POLL_LEVEL),
        .DOUT(DOUT), .DOE(DOE), .INIT_DONE(INIT_DONE), .LTIM(LTIM), .SNGL(SNGL),
        .VEC_BASE(VEC_BASE), .CAS_CFG(CAS_CFG), .ICW4_CFG(ICW4_CFG), .IMR(IMR),
        .OCW2_STB(OCW2_STB), .OCW2_CMD(OCW2_CMD), .OCW2_LVL(OCW2_LVL), .SMM(SMM), .POLL_ACK(POLL_ACK));

    pic_cmd_interface #(.NUM_IR(4), .LVL_W(3)) u4 (
        .CLK(CLK), .RST_N(RST_N), .CS_N(CS_N), .WR_N(WR_N), .RD_N(RD_N), .A0(A0), .DIN(DIN),
        .IRR(IRR[3:0]), .ISR(ISR[3:0]), .POLL_VALID(POLL_VALID), .POLL_LEVEL(POLL_LEVEL),
        .DOUT(dout4), .DOE(doe4), .INIT_DONE(init4), .LTIM(ltim4), .SNGL(sngl4),
        .VEC_BASE(vec4), .CAS_CFG(cas4), .ICW4_CFG(icw4_4), .IMR(imr4),
        .OCW2_STB(stb4), .OCW2_CMD(cmd4), .OCW2_LVL(lvl4), .SMM(smm4), .POLL_ACK(ack4));

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // monitor: every new read-data presentation is scored against the oldest expected read
    always @(negedge CLK) begin
        if (RST_N) begin
            if (DOE && !doe_q) begin
                if (exp_q.size() == 0) chk("unexpected_doe", DOE, 0);
                else chk("rd_data", DOUT, exp_q.pop_front());
            end
            if (!DOE) chk("dout_idle", DOUT, 0);
        end
        doe_q = DOE;
    end

    task automatic model_reset();
        ph = 0; m_sngl = 0; m_ic4 = 0; m_ltim = 0; m_smm = 0; m_rsel = 0; m_poll = 0; m_stb = 0;
        m_vec = 0; m_icw4 = 0; m_cas = 0; m_imr = 0; m_cmd = 0; m_lvl = 0;
    endtask

    // command-level reference: phase 0 idle, 1..3 awaiting ICW2..ICW4, 4 ready
    task automatic model_write(input bit a0, input logic [7:0] d);
        m_stb = 0;
        if (!a0 && d[4]) begin
            ph = 1; m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
            m_imr = 0; m_smm = 0; m_rsel = 0; m_poll = 0; m_cas = 0; m_icw4 = 0;
        end else if (a0 && ph == 1) begin
            m_vec = d[7:3];
            ph = !m_sngl ? 2 : m_ic4 ? 3 : 4;
        end else if (a0 && ph == 2) begin
            m_cas = d;
            ph = m_ic4 ? 3 : 4;
        end else if (a0 && ph == 3) begin
            m_icw4 = d[4:0];
            ph = 4;
        end else if (ph == 4) begin
            if (a0) m_imr = d;
            else if (!d[3]) begin
                m_stb = 1; m_cmd = d[7:5]; m_lvl = d[2:0];
            end else begin
                if (d[1]) m_rsel = d[0];
                if (d[6]) m_smm = d[5];
`ifdef PIC_POLL_CMD_EN
                if (d[2]) m_poll = 1;
`endif
            end
        end
    endtask

    task automatic check_regs();
        chk("init_done", INIT_DONE, ph == 4);
        chk("ltim", LTIM, m_ltim);
        chk("sngl", SNGL, m_sngl);
        chk("vec_base", VEC_BASE, m_vec);
        chk("cas_cfg", CAS_CFG, m_cas);
        chk("icw4_cfg", ICW4_CFG, m_icw4);
        chk("imr", IMR, m_imr);
        chk("imr4", imr4, m_imr[3:0]);
        chk("ocw2_stb", OCW2_STB, m_stb);
        chk("ocw2_cmd", OCW2_CMD, m_cmd);
        chk("ocw2_lvl", OCW2_LVL, m_lvl);
        chk("smm", SMM, m_smm);
    endtask

    task automatic bus_write(input bit a0, input logic [7:0] d, input int hold = 1);
        @(negedge CLK);
        A0 = a0; DIN = d; CS_N = 0; WR_N = 0;
        model_write(a0, d);
        @(negedge CLK);
        check_regs();
        for (int i = 1; i < hold; i++) begin
            @(negedge CLK);
            chk("ocw2_stb_once", OCW2_STB, 0);
        end
        CS_N = 1; WR_N = 1;
        m_stb = 0;
    endtask

    task automatic bus_read(input bit a0);
        bit poll, ack;
        @(negedge CLK);
        A0 = a0; CS_N = 0; RD_N = 0;
        poll = m_poll && !a0;
        ack = poll && POLL_VALID;
        exp_q.push_back(poll ? {POLL_VALID, 4'b0, POLL_LEVEL} : a0 ? m_imr : m_rsel ? ISR : IRR);
        if (poll) m_poll = 0;
        @(negedge CLK);
        chk("doe_after_event", DOE, 1);
        chk("poll_ack", POLL_ACK, ack);
        if (a0) chk("dout4", dout4, {4'b0, m_imr[3:0]});
        IRR = $urandom; ISR = $urandom;
        @(negedge CLK);
        chk("poll_ack_end", POLL_ACK, 0);
        CS_N = 1; RD_N = 1;
        @(negedge CLK);
        chk("doe_released", DOE, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge CLK);
        chk("rst_init_done", INIT_DONE, 0);
        chk("rst_imr", IMR, 0);
        chk("rst_vec", VEC_BASE, 0);
        chk("rst_doe", DOE, 0);
        chk("rst_dout", DOUT, 0);
        RST_N = 1;
        bus_write(0, 8'h13);
        bus_write(1, 8'h20);
        chk("tp_init_early", INIT_DONE, 0);
        bus_write(1, 8'h03);
        chk("tp_vec", VEC_BASE, 5'h04);
        chk("tp_icw4", ICW4_CFG, 5'h03);
        chk("tp_init_done", INIT_DONE, 1);
        bus_write(0, 8'h11); bus_write(1, 8'h08); bus_write(1, 8'h04); bus_write(1, 8'h01);
        chk("tp_cas", CAS_CFG, 8'h04);
        bus_write(0, 8'h11); bus_write(1, 8'h08); bus_write(1, 8'h04);
        bus_write(0, 8'h10);
        chk("tp_restart_init", INIT_DONE, 0);
        chk("tp_restart_cas", CAS_CFG, 0);
        bus_write(1, 8'h08); bus_write(1, 8'h04);
        bus_write(1, 8'hA5);
        chk("tp_imr4", imr4, 4'h5);
        bus_read(1);
        bus_write(0, 8'h61, 5);
        bus_write(0, 8'h0B); ISR = 8'h10; bus_read(0);
        bus_write(0, 8'h0A); IRR = 8'h81; bus_read(0);
        bus_write(0, 8'h68);
        chk("tp_smm", SMM, 1);
        bus_write(0, 8'h0C); POLL_VALID = 1; POLL_LEVEL = 5;
        bus_read(0);
        bus_read(0);
        // write and read strobes low together: only the write counts
        @(negedge CLK);
        A0 = 1; DIN = 8'h3C; CS_N = 0; WR_N = 0; RD_N = 0;
        model_write(1, 8'h3C);
        @(negedge CLK);
        check_regs();
        chk("collide_doe", DOE, 0);
        CS_N = 1; WR_N = 1; RD_N = 1; m_stb = 0;
        // reset while a write strobe is held low must not yield an event afterwards
        @(negedge CLK);
        A0 = 0; DIN = 8'h13; CS_N = 0; WR_N = 0; RST_N = 0;
        repeat (2) @(negedge CLK);
        RST_N = 1; model_reset();
        repeat (2) @(negedge CLK);
        chk("held_strobe_init", INIT_DONE, 0);
        CS_N = 1; WR_N = 1;
        bus_write(1, 8'h20);
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) bus_write(1'($urandom), 8'($urandom));
            else if (r < 8) bus_read(1'($urandom));
            else begin
                IRR = $urandom; ISR = $urandom; POLL_VALID = 1'($urandom); POLL_LEVEL = 3'($urandom);
            end
        end
        repeat (3) @(negedge CLK);
        chk("reads_all_served", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
